regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Owns the single write port (DA, D, W) of the 32x64 register file.
- After reset, clears registers 0..30 with an init sweep.
- Then shares the write port round-robin between two writeback requesters, for example ALU writeback and load writeback.
- Register 31 is the hardwired zero register: writes to it are accepted and discarded.

Parameters:
- DATA_W, 64, data width of the register file write port
- ADDR_W, 5, register address width
- ZERO_REG, 31, register index that is never written
- INIT_CLEAR, 1, 1 = run the clear sweep after reset; 0 = go straight to RUN

Ports:
- clock  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- w0_valid  in  1  requester 0 has a write pending
- w0_addr  in  ADDR_W  requester 0 destination register
- w0_data  in  DATA_W  requester 0 write data
- w0_ready  out  1  requester 0 write accepted this cycle
- w1_valid  in  1  requester 1 has a write pending
- w1_addr  in  ADDR_W  requester 1 destination register
- w1_data  in  DATA_W  requester 1 write data
- w1_ready  out  1  requester 1 write accepted this cycle
- DA  out  ADDR_W  register file write address (registered)
- D  out  DATA_W  register file write data (registered)
- W  out  1  register file write enable (registered)
- grant  out  2  one-hot record of which requester was issued into DA/D/W this cycle (registered); 00 = none
- init_done  out  1  high once the clear sweep has finished

Behaviour:
- Reset low (asynchronous): W=0, DA=0, D=0, grant=00, init_done=0, init_cnt=0, rr_ptr=0 (requester 0 favoured), state=INIT (INIT_CLEAR=1) or RUN.
- Reset low also forces w0_ready=w1_ready=0 combinationally.
- States: INIT, RUN. No other states.
- INIT:
  - Each rising edge loads W=1, DA=init_cnt, D=0, then increments init_cnt.
  - Sweep covers DA=0..30 over 31 consecutive cycles; DA=31 is never driven with W=1.
  - On the edge after the DA=30 cycle: W=0, init_done=1, state=RUN.
  - w0_ready and w1_ready are 0 throughout INIT. Requests are held off, not dropped.
- RUN, combinational grant:
  - Exactly one valid requester: that requester wins.
  - Both valid: requester rr_ptr wins.
  - Winner's ready=1, other ready=0. Ready depends combinationally on valid; requesters must not make valid depend on ready.
- RUN, acceptance (valid & ready) at a rising edge:
  - DA<=addr, D<=data, W<=(addr != ZERO_REG).
  - grant<=one-hot of winner.
  - rr_ptr<=index of the non-winner.
- RUN, no acceptance: W<=0, grant<=00, DA and D hold, rr_ptr holds.
- Latency:
  - Acceptance edge N drives DA/D/W during cycle N..N+1.
  - The register file captures the data at edge N+1.
  - Throughput is one write per cycle.
- Writes to ZERO_REG: consume the slot, ready=1 and grant set, W=0.
- Same address from both requesters in the same cycle: only the winner is accepted; the loser stays pending and is issued next cycle (last writer wins in the file).
- Reset mid-INIT or mid-RUN: immediate return to reset values; INIT restarts from DA=0.
- init_done stays 1 until the next reset.

Test Plan:
- Release reset with no requests -> W=1 for exactly 31 cycles, DA=0,1,...,30 and D=0 each cycle; then W=0, init_done=1; w0_ready=w1_ready=0 throughout the sweep.
- In RUN, w0_valid=1, w0_addr=5, w0_data=0x00000000DEADBEEF for one cycle -> w0_ready=1 that cycle; next cycle DA=5, D=0x00000000DEADBEEF, W=1, grant=01; following cycle W=0, grant=00.
- Both valid for 4 cycles with rr_ptr=0, addrs 1 and 2 -> grant sequence 01,10,01,10; DA sequence 1,2,1,2; in each cycle only the winning ready is high.
- w1_valid=1, w1_addr=31, w1_data=0xFFFF_FFFF_FFFF_FFFF -> w1_ready=1; next cycle grant=10 and W=0.
- Assert reset while the sweep is at DA=12 -> W, DA, D and init_done go to 0 without waiting for a clock edge; after release the sweep restarts at DA=0 and runs 31 cycles.
- w0 alone issues addrs 1, 2, 3 back-to-back with data 0xA, 0xB, 0xC -> W high for 3 consecutive cycles with DA=1, 2, 3 and D=0xA, 0xB, 0xC; no bubble cycles.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Write-port owner for the 32x64 register file: clears registers after reset,
// then arbitrates two writeback requesters round-robin onto DA/D/W.
module regfile_write_arbiter #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned ZERO_REG   = 31,
    parameter bit          INIT_CLEAR = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              w0_valid,
    input  logic [ADDR_W-1:0] w0_addr,
    input  logic [DATA_W-1:0] w0_data,
    output logic              w0_ready,
    input  logic              w1_valid,
    input  logic [ADDR_W-1:0] w1_addr,
    input  logic [DATA_W-1:0] w1_data,
    output logic              w1_ready,
    output logic [ADDR_W-1:0] DA,
    output logic [DATA_W-1:0] D,
    output logic              W,
    output logic [1:0]        grant,
    output logic              init_done
);

    localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W-1:0] LastCnt  = {ADDR_W{1'b1}};

    typedef enum logic {StInit, StRun} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
    logic [ADDR_W-1:0]   da_q, da_d;
    logic [DATA_W-1:0]   d_q, d_d;
    logic                w_q, w_d;
    logic [1:0]          grant_q, grant_d;
    logic                init_done_q, init_done_d;
    logic                rr_ptr_q, rr_ptr_d;
    logic                run, pick1;

    // Ready is gated by reset so requesters see no acceptance while held in reset.
    always_comb begin
        run      = reset && (state_q == StRun);
        pick1    = w1_valid && (!w0_valid || rr_ptr_q);
        w0_ready = run && w0_valid && !pick1;
        w1_ready = run && pick1;
    end

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        da_d        = da_q;
        d_d         = d_q;
        w_d         = 1'b0;
        grant_d     = 2'b00;
        init_done_d = init_done_q;
        rr_ptr_d    = rr_ptr_q;
        unique case (state_q)
            StInit: begin
                // Count reaching all-ones means the last clearable register was issued.
                if (init_cnt_q == LastCnt) begin
                    state_d     = StRun;
                    init_done_d = 1'b1;
                end else begin
                    w_d        = 1'b1;
                    da_d       = init_cnt_q;
                    d_d        = '0;
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (w0_ready) begin
                    da_d     = w0_addr;
                    d_d      = w0_data;
                    w_d      = (w0_addr != ZeroAddr);
                    grant_d  = 2'b01;
                    rr_ptr_d = 1'b1;
                end else if (w1_ready) begin
                    da_d     = w1_addr;
                    d_d      = w1_data;
                    w_d      = (w1_addr != ZeroAddr);
                    grant_d  = 2'b10;
                    rr_ptr_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= INIT_CLEAR ? StInit : StRun;
            init_cnt_q  <= '0;
            da_q        <= '0;
            d_q         <= '0;
            w_q         <= 1'b0;
            grant_q     <= 2'b00;
            init_done_q <= 1'b0;
            rr_ptr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            da_q        <= da_d;
            d_q         <= d_d;
            w_q         <= w_d;
            grant_q     <= grant_d;
            init_done_q <= init_done_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign DA        = da_q;
    assign D         = d_q;
    assign W         = w_q;
    assign grant     = grant_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: init sweep, arbitration, zero register,
// back-to-back issue and asynchronous reset behaviour.
module tb_regfile_write_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        w0_valid, w1_valid;
    logic [4:0]  w0_addr, w1_addr;
    logic [63:0] w0_data, w1_data;
    logic        w0_ready, w1_ready;
    logic [4:0]  DA;
    logic [63:0] D;
    logic        W;
    logic [1:0]  grant;
    logic        init_done;

    int n_cmp = 0;
    int n_err = 0;

    regfile_write_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .w0_valid  (w0_valid),
        .w0_addr   (w0_addr),
        .w0_data   (w0_data),
        .w0_ready  (w0_ready),
        .w1_valid  (w1_valid),
        .w1_addr   (w1_addr),
        .w1_data   (w1_data),
        .w1_ready  (w1_ready),
        .DA        (DA),
        .D         (D),
        .W         (W),
        .grant     (grant),
        .init_done (init_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks the first n cycles of the clear sweep, sampling on the falling edge.
    task automatic sweep(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            @(negedge clock);
            chk("sweep_W", 64'(W), 64'd1);
            chk("sweep_DA", 64'(DA), 64'(i));
            chk("sweep_D", D, 64'd0);
            chk("sweep_grant", 64'(grant), 64'd0);
            chk("sweep_done", 64'(init_done), 64'd0);
            chk("sweep_rdy0", 64'(w0_ready), 64'd0);
            chk("sweep_rdy1", 64'(w1_ready), 64'd0);
        end
    endtask

    task automatic step;
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        reset    = 1'b0;
        w0_valid = 1'b1;
        w1_valid = 1'b1;
        w0_addr  = 5'd3;
        w1_addr  = 5'd4;
        w0_data  = 64'h11;
        w1_data  = 64'h22;

        // Reset state, with requests pending so ready gating is visible.
        #2;
        chk("rst_W", 64'(W), 64'd0);
        chk("rst_DA", 64'(DA), 64'd0);
        chk("rst_D", D, 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_done", 64'(init_done), 64'd0);
        chk("rst_rdy0", 64'(w0_ready), 64'd0);
        chk("rst_rdy1", 64'(w1_ready), 64'd0);

        // Release on a falling edge; requests stay held off during the sweep.
        @(negedge clock);
        reset = 1'b1;
        sweep(31);
        step();
        chk("end_W", 64'(W), 64'd0);
        chk("end_done", 64'(init_done), 64'd1);
        chk("end_rdy0", 64'(w0_ready), 64'd1);
        chk("end_rdy1", 64'(w1_ready), 64'd0);
        w0_valid = 1'b0;
        w1_valid = 1'b0;
        #1;
        chk("idle_rdy0", 64'(w0_ready), 64'd0);

        // Single w0 write.
        @(negedge clock);
        w0_valid = 1'b1;
        w0_addr  = 5'd5;
        w0_data  = 64'h0000_0000_DEAD_BEEF;
        #1;
        chk("single_rdy0", 64'(w0_ready), 64'd1);
        step();
        w0_valid = 1'b0;
        chk("single_DA", 64'(DA), 64'd5);
        chk("single_D", D, 64'h0000_0000_DEAD_BEEF);
        chk("single_W", 64'(W), 64'd1);
        chk("single_grant", 64'(grant), 64'b01);
        step();
        chk("single_W2", 64'(W), 64'd0);
        chk("single_grant2", 64'(grant), 64'b00);
        chk("single_DA_hold", 64'(DA), 64'd5);

        // w1 write to the zero register: slot consumed, no file write.
        w1_valid = 1'b1;
        w1_addr  = 5'd31;
        w1_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        chk("zero_rdy1", 64'(w1_ready), 64'd1);
        step();
        w1_valid = 1'b0;
        chk("zero_grant", 64'(grant), 64'b10);
        chk("zero_W", 64'(W), 64'd0);

        // Both valid for four cycles starting with requester 0 favoured.
        w0_valid = 1'b1;
        w0_addr  = 5'd1;
        w0_data  = 64'h100;
        w1_valid = 1'b1;
        w1_addr  = 5'd2;
        w1_data  = 64'h200;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_rdy0", 64'(w0_ready), (k % 2 == 0) ? 64'd1 : 64'd0);
            chk("rr_rdy1", 64'(w1_ready), (k % 2 == 0) ? 64'd0 : 64'd1);
            step();
            chk("rr_grant", 64'(grant), (k % 2 == 0) ? 64'b01 : 64'b10);
            chk("rr_DA", 64'(DA), (k % 2 == 0) ? 64'd1 : 64'd2);
            chk("rr_W", 64'(W), 64'd1);
        end
        w0_valid = 1'b0;
        w1_valid = 1'b0;
        step();
        chk("rr_idle_W", 64'(W), 64'd0);

        // w0 back-to-back, no bubbles.
        w0_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            w0_addr = 5'(k + 1);
            w0_data = 64'hA + 64'(k);
            step();
            chk("b2b_W", 64'(W), 64'd1);
            chk("b2b_DA", 64'(DA), 64'(k + 1));
            chk("b2b_D", D, 64'hA + 64'(k));
        end
        w0_valid = 1'b0;
        step();
        chk("b2b_idle_W", 64'(W), 64'd0);

        // Same address from both: rr_ptr now favours w1; loser issued next cycle.
        w0_valid = 1'b1;
        w0_addr  = 5'd7;
        w0_data  = 64'h1;
        w1_valid = 1'b1;
        w1_addr  = 5'd7;
        w1_data  = 64'h2;
        step();
        w1_valid = 1'b0;
        chk("same_grant1", 64'(grant), 64'b10);
        chk("same_D1", D, 64'h2);
        step();
        w0_valid = 1'b0;
        chk("same_grant2", 64'(grant), 64'b01);
        chk("same_D2", D, 64'h1);
        chk("same_DA2", 64'(DA), 64'd7);

        // Reset in RUN clears asynchronously.
        reset = 1'b0;
        #1;
        chk("runrst_done", 64'(init_done), 64'd0);
        chk("runrst_DA", 64'(DA), 64'd0);
        chk("runrst_D", D, 64'd0);
        chk("runrst_grant", 64'(grant), 64'd0);
        #2;
        reset = 1'b1;

        // Reset at DA=12 mid-sweep, then a full restart.
        sweep(13);
        #2;
        reset = 1'b0;
        #1;
        chk("initrst_W", 64'(W), 64'd0);
        chk("initrst_DA", 64'(DA), 64'd0);
        chk("initrst_D", D, 64'd0);
        chk("initrst_done", 64'(init_done), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        sweep(31);
        step();
        chk("restart_W", 64'(W), 64'd0);
        chk("restart_done", 64'(init_done), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
